// File: rtl/taxi_fare_pkg.sv
// rtl/taxi_fare_pkg.sv - shared tariff types, field codes, default tariffs and BCD nibble helper
package taxi_fare_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_EDIT_S = 2'd1,
      ST_EDIT_D = 2'd2,
      ST_EDIT_W = 2'd3
   } edit_state_e;

   localparam logic [1:0] FIELD_S    = 2'd0;
   localparam logic [1:0] FIELD_DIST = 2'd1;
   localparam logic [1:0] FIELD_WAIT = 2'd2;

   localparam int DIGIT_W = 4;
   localparam int WORD_W  = 12;

   localparam logic [WORD_W-1:0] S_FARE_DEF    = 12'h100;
   localparam logic [WORD_W-1:0] DIST_FARE_DEF = 12'h002;
   localparam logic [WORD_W-1:0] WAIT_FARE_DEF = 12'h010;

   localparam logic [1:0] DIGIT_MS = 2'd2;

   // Single-digit BCD increment: no carry out, out-of-range nibbles restart at 0.
   function automatic logic [DIGIT_W-1:0] bcd_inc(input logic [DIGIT_W-1:0] n);
      return (n >= 4'd9) ? 4'd0 : n + 4'd1;
   endfunction

   function automatic logic [WORD_W-1:0] bump_digit(input logic [WORD_W-1:0] word,
                                                    input logic [1:0]        digit);
      logic [WORD_W-1:0] res;
      res = word;
      case (digit)
         2'd0:    res[3:0]  = bcd_inc(word[3:0]);
         2'd1:    res[7:4]  = bcd_inc(word[7:4]);
         default: res[11:8] = bcd_inc(word[11:8]);
      endcase
      return res;
   endfunction

endpackage

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - synchronizer, level debounce and one-cycle rising-edge press for one button
module key_debounce #(
   parameter logic [19:0] DEBOUNCE_COUNT = 20'd1_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic key_raw,
   output logic level,
   output logic press
);

   logic        sync1_q, sync1_d;
   logic        sync2_q, sync2_d;
   logic        level_q, level_d;
   logic        level_dly_q, level_dly_d;
   logic        press_q, press_d;
   logic [19:0] cnt_q, cnt_d;

   always_comb begin
      sync1_d     = key_raw;
      sync2_d     = sync1_q;
      level_d     = level_q;
      level_dly_d = level_q;
      press_d     = level_q & ~level_dly_q;
      cnt_d       = 20'd0;
      // Any sample matching the accepted level restarts the stability count.
      if (sync2_q != level_q) begin
         if (cnt_q >= DEBOUNCE_COUNT - 20'd1) begin
            level_d = sync2_q;
         end else begin
            cnt_d = cnt_q + 20'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q     <= 1'b0;
         sync2_q     <= 1'b0;
         level_q     <= 1'b0;
         level_dly_q <= 1'b0;
         press_q     <= 1'b0;
         cnt_q       <= 20'd0;
      end else begin
         sync1_q     <= sync1_d;
         sync2_q     <= sync2_d;
         level_q     <= level_d;
         level_dly_q <= level_dly_d;
         press_q     <= press_d;
         cnt_q       <= cnt_d;
      end
   end

   assign level = level_q;
   assign press = press_q;

endmodule

// File: rtl/tariff_config.sv
// rtl/tariff_config.sv - tariff edit FSM with shadow/live BCD words; TARIFF_AUTOREPEAT_EN adds held-inc repeat
module tariff_config
   import taxi_fare_pkg::*;
#(
   parameter logic [19:0] DEBOUNCE_COUNT = 20'd1_000_000,
   parameter logic [24:0] REPEAT_COUNT   = 25'd25_000_000,
   parameter logic [11:0] S_FARE_INIT    = S_FARE_DEF,
   parameter logic [11:0] DIST_FARE_INIT = DIST_FARE_DEF,
   parameter logic [11:0] WAIT_FARE_INIT = WAIT_FARE_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  logic        key_mode,
   input  logic        key_next,
   input  logic        key_inc,
   output logic [11:0] s_fare,
   output logic [11:0] distance_fare_per_pulse,
   output logic [11:0] wait_fare_per_unit,
   output logic        edit_active,
   output logic [1:0]  edit_field,
   output logic [1:0]  edit_digit,
   output logic        cfg_update
);

   logic mode_press, next_press, inc_press;
   logic mode_level, next_level, inc_level;
   logic rep_fire;

   edit_state_e state_q, state_d;
   logic [1:0]  digit_q, digit_d;
   logic [11:0] live_s_q, live_s_d, live_d_q, live_d_d, live_w_q, live_w_d;
   logic [11:0] sh_s_q, sh_s_d, sh_d_q, sh_d_d, sh_w_q, sh_w_d;
   logic        cfg_q, cfg_d;

   key_debounce #(.DEBOUNCE_COUNT(DEBOUNCE_COUNT)) u_db_mode (
      .clk(clk), .rst(rst), .key_raw(key_mode), .level(mode_level), .press(mode_press));
   key_debounce #(.DEBOUNCE_COUNT(DEBOUNCE_COUNT)) u_db_next (
      .clk(clk), .rst(rst), .key_raw(key_next), .level(next_level), .press(next_press));
   key_debounce #(.DEBOUNCE_COUNT(DEBOUNCE_COUNT)) u_db_inc (
      .clk(clk), .rst(rst), .key_raw(key_inc), .level(inc_level), .press(inc_press));

`ifdef TARIFF_AUTOREPEAT_EN
   logic [24:0] rep_cnt_q, rep_cnt_d;
   logic        rep_hold;
   logic        unused_levels;
   assign unused_levels = ^{mode_level, next_level};

   // Repeat interval is measured from the initial press; any state/digit change restarts it.
   always_comb begin
      rep_hold  = (state_q != ST_IDLE) & inc_level & ~en & ~mode_press & ~next_press;
      rep_fire  = rep_hold & ~inc_press & (rep_cnt_q == REPEAT_COUNT - 25'd1);
      rep_cnt_d = (!rep_hold || inc_press || rep_fire) ? 25'd0 : rep_cnt_q + 25'd1;
   end

   always_ff @(posedge clk) begin
      if (rst) rep_cnt_q <= 25'd0;
      else     rep_cnt_q <= rep_cnt_d;
   end
`else
   logic unused_levels;
   assign unused_levels = ^{mode_level, next_level, inc_level, REPEAT_COUNT};
   assign rep_fire      = 1'b0;
`endif

   always_comb begin
      state_d  = state_q;
      digit_d  = digit_q;
      live_s_d = live_s_q;
      live_d_d = live_d_q;
      live_w_d = live_w_q;
      sh_s_d   = sh_s_q;
      sh_d_d   = sh_d_q;
      sh_w_d   = sh_w_q;
      cfg_d    = 1'b0;
      if (state_q == ST_IDLE) begin
         if (mode_press && !en) begin
            sh_s_d  = live_s_q;
            sh_d_d  = live_d_q;
            sh_w_d  = live_w_q;
            state_d = ST_EDIT_S;
            digit_d = DIGIT_MS;
         end
      end else if (en) begin
         state_d = ST_IDLE;
         digit_d = DIGIT_MS;
      end else if (mode_press) begin
         digit_d = DIGIT_MS;
         case (state_q)
            ST_EDIT_S: state_d = ST_EDIT_D;
            ST_EDIT_D: state_d = ST_EDIT_W;
            default: begin
               state_d  = ST_IDLE;
               live_s_d = sh_s_q;
               live_d_d = sh_d_q;
               live_w_d = sh_w_q;
               cfg_d    = 1'b1;
            end
         endcase
      end else if (next_press) begin
         digit_d = (digit_q == 2'd0) ? DIGIT_MS : digit_q - 2'd1;
      end else if (inc_press || rep_fire) begin
         case (state_q)
            ST_EDIT_S: sh_s_d = bump_digit(sh_s_q, digit_q);
            ST_EDIT_D: sh_d_d = bump_digit(sh_d_q, digit_q);
            default:   sh_w_d = bump_digit(sh_w_q, digit_q);
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         digit_q  <= DIGIT_MS;
         live_s_q <= S_FARE_INIT;
         live_d_q <= DIST_FARE_INIT;
         live_w_q <= WAIT_FARE_INIT;
         sh_s_q   <= S_FARE_INIT;
         sh_d_q   <= DIST_FARE_INIT;
         sh_w_q   <= WAIT_FARE_INIT;
         cfg_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         digit_q  <= digit_d;
         live_s_q <= live_s_d;
         live_d_q <= live_d_d;
         live_w_q <= live_w_d;
         sh_s_q   <= sh_s_d;
         sh_d_q   <= sh_d_d;
         sh_w_q   <= sh_w_d;
         cfg_q    <= cfg_d;
      end
   end

   always_comb begin
      case (state_q)
         ST_EDIT_S: edit_field = FIELD_S;
         ST_EDIT_D: edit_field = FIELD_DIST;
         ST_EDIT_W: edit_field = FIELD_WAIT;
         default:   edit_field = FIELD_S;
      endcase
   end

   assign edit_active             = (state_q != ST_IDLE);
   assign edit_digit              = digit_q;
   assign cfg_update              = cfg_q;
   assign s_fare                  = live_s_q;
   assign distance_fare_per_pulse = live_d_q;
   assign wait_fare_per_unit      = live_w_q;

endmodule

// File: tb/tb_tariff_config.sv
// tb/tb_tariff_config.sv - directed vector bench for tariff_config
module tb_tariff_config;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        en = 1'b0;
   logic        key_mode = 1'b0;
   logic        key_next = 1'b0;
   logic        key_inc = 1'b0;
   logic [11:0] s_fare, distance_fare_per_pulse, wait_fare_per_unit;
   logic        edit_active;
   logic [1:0]  edit_field, edit_digit;
   logic        cfg_update;

   int n_vec = 0;
   int n_err = 0;
   int cfg_cnt = 0;
   logic [35:0] prev_live = '0;

   always #5 clk = ~clk;

   tariff_config #(.DEBOUNCE_COUNT(20'd4), .REPEAT_COUNT(25'd8)) dut (
      .clk(clk), .rst(rst), .en(en),
      .key_mode(key_mode), .key_next(key_next), .key_inc(key_inc),
      .s_fare(s_fare), .distance_fare_per_pulse(distance_fare_per_pulse),
      .wait_fare_per_unit(wait_fare_per_unit),
      .edit_active(edit_active), .edit_field(edit_field), .edit_digit(edit_digit),
      .cfg_update(cfg_update));

   // Live words may only move on a cfg_update cycle (or under reset).
   always @(negedge clk) begin
      if (cfg_update) cfg_cnt++;
      if (!rst && prev_live !== {s_fare, distance_fare_per_pulse, wait_fare_per_unit} && !cfg_update) begin
         n_err++;
         $display("FAIL live_change: got %h was %h without cfg_update",
                  {s_fare, distance_fare_per_pulse, wait_fare_per_unit}, prev_live);
      end
      prev_live = {s_fare, distance_fare_per_pulse, wait_fare_per_unit};
   end

   typedef struct {
      int          op;
      int          reps;
      logic [11:0] s, d, w;
      logic        act;
      logic [1:0]  fld, dig;
      int          cfg;
   } vec_t;

   localparam int OP_MODE = 0, OP_NEXT = 1, OP_INC = 2;
   localparam int NV = 21;
   vec_t vecs[NV];

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   function automatic logic [63:0] outs();
      return {23'd0, s_fare, distance_fare_per_pulse, wait_fare_per_unit,
              edit_active, edit_field, edit_digit};
   endfunction

   function automatic logic [63:0] pack(input logic [11:0] s, d, w, input logic act,
                                        input logic [1:0] fld, dig);
      return {23'd0, s, d, w, act, fld, dig};
   endfunction

   task automatic press(input int op);
      case (op)
         OP_MODE: key_mode = 1'b1;
         OP_NEXT: key_next = 1'b1;
         default: key_inc  = 1'b1;
      endcase
      repeat (10) @(negedge clk);
      key_mode = 1'b0;
      key_next = 1'b0;
      key_inc  = 1'b0;
      repeat (10) @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      int base;
      int k;
      logic [11:0] s_ar;

      vecs[0]  = '{OP_MODE, 1, 12'h100, 12'h002, 12'h010, 1'b1, 2'd0, 2'd2, 0};
      vecs[1]  = '{OP_NEXT, 1, 12'h100, 12'h002, 12'h010, 1'b1, 2'd0, 2'd1, 0};
      vecs[2]  = '{OP_INC,  3, 12'h100, 12'h002, 12'h010, 1'b1, 2'd0, 2'd1, 0};
      vecs[3]  = '{OP_MODE, 1, 12'h100, 12'h002, 12'h010, 1'b1, 2'd1, 2'd2, 0};
      vecs[4]  = '{OP_MODE, 1, 12'h100, 12'h002, 12'h010, 1'b1, 2'd2, 2'd2, 0};
      vecs[5]  = '{OP_MODE, 1, 12'h130, 12'h002, 12'h010, 1'b0, 2'd0, 2'd2, 1};
      vecs[6]  = '{OP_MODE, 2, 12'h130, 12'h002, 12'h010, 1'b1, 2'd1, 2'd2, 0};
      vecs[7]  = '{OP_NEXT, 1, 12'h130, 12'h002, 12'h010, 1'b1, 2'd1, 2'd1, 0};
      vecs[8]  = '{OP_INC,  1, 12'h130, 12'h002, 12'h010, 1'b1, 2'd1, 2'd1, 0};
      vecs[9]  = '{OP_NEXT, 1, 12'h130, 12'h002, 12'h010, 1'b1, 2'd1, 2'd0, 0};
      vecs[10] = '{OP_INC,  7, 12'h130, 12'h002, 12'h010, 1'b1, 2'd1, 2'd0, 0};
      vecs[11] = '{OP_MODE, 2, 12'h130, 12'h019, 12'h010, 1'b0, 2'd0, 2'd2, 1};
      vecs[12] = '{OP_MODE, 2, 12'h130, 12'h019, 12'h010, 1'b1, 2'd1, 2'd2, 0};
      vecs[13] = '{OP_NEXT, 2, 12'h130, 12'h019, 12'h010, 1'b1, 2'd1, 2'd0, 0};
      vecs[14] = '{OP_INC,  1, 12'h130, 12'h019, 12'h010, 1'b1, 2'd1, 2'd0, 0};
      vecs[15] = '{OP_MODE, 2, 12'h130, 12'h010, 12'h010, 1'b0, 2'd0, 2'd2, 1};
      vecs[16] = '{OP_MODE, 3, 12'h130, 12'h010, 12'h010, 1'b1, 2'd2, 2'd2, 0};
      vecs[17] = '{OP_INC,  1, 12'h130, 12'h010, 12'h010, 1'b1, 2'd2, 2'd2, 0};
      vecs[18] = '{OP_NEXT, 1, 12'h130, 12'h010, 12'h010, 1'b1, 2'd2, 2'd1, 0};
      vecs[19] = '{OP_INC,  2, 12'h130, 12'h010, 12'h010, 1'b1, 2'd2, 2'd1, 0};
      vecs[20] = '{OP_MODE, 1, 12'h130, 12'h010, 12'h130, 1'b0, 2'd0, 2'd2, 1};

      do_reset();
      check("reset_outs", outs(), pack(12'h100, 12'h002, 12'h010, 1'b0, 2'd0, 2'd2));
      check("reset_cfg", {63'd0, cfg_update}, 64'd0);

      for (int i = 0; i < NV; i++) begin
         base = cfg_cnt;
         for (int r = 0; r < vecs[i].reps; r++) press(vecs[i].op);
         check($sformatf("vec%0d_outs", i), outs(),
               pack(vecs[i].s, vecs[i].d, vecs[i].w, vecs[i].act, vecs[i].fld, vecs[i].dig));
         check($sformatf("vec%0d_cfg", i), 64'(cfg_cnt - base), 64'(vecs[i].cfg));
      end

      // Simultaneous mode+next: only mode acts.
      key_mode = 1'b1;
      key_next = 1'b1;
      repeat (10) @(negedge clk);
      key_mode = 1'b0;
      key_next = 1'b0;
      repeat (10) @(negedge clk);
      check("prio_mode_over_next", outs(), pack(12'h130, 12'h010, 12'h130, 1'b1, 2'd0, 2'd2));

      press(OP_INC);
      do_reset();
      check("reset_mid_edit", outs(), pack(12'h100, 12'h002, 12'h010, 1'b0, 2'd0, 2'd2));

      // Bounce on key_mode, then a clean rise: EDIT_S 8 cycles after the final rise.
      for (int t = 0; t < 10; t++) begin
         key_mode = ~key_mode;
         repeat (2) @(negedge clk);
      end
      check("bounce_no_press", {63'd0, edit_active}, 64'd0);
      key_mode = 1'b1;
      k = 0;
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk);
         if (edit_active && k == 0) k = c;
      end
      key_mode = 1'b0;
      repeat (10) @(negedge clk);
      check("bounce_latency", 64'(k), 64'd8);

      // Abort from EDIT_D.
      base = cfg_cnt;
      press(OP_INC);
      press(OP_MODE);
      check("abort_in_edit_d", outs(), pack(12'h100, 12'h002, 12'h010, 1'b1, 2'd1, 2'd2));
      en = 1'b1;
      @(negedge clk);
      check("abort_idle", outs(), pack(12'h100, 12'h002, 12'h010, 1'b0, 2'd0, 2'd2));
      press(OP_MODE);
      check("mode_locked", outs(), pack(12'h100, 12'h002, 12'h010, 1'b0, 2'd0, 2'd2));
      check("abort_no_cfg", 64'(cfg_cnt - base), 64'd0);
      en = 1'b0;
      @(negedge clk);

      // Abort coinciding with the commit press in EDIT_W.
      base = cfg_cnt;
      repeat (3) press(OP_MODE);
      press(OP_INC);
      key_mode = 1'b1;
      repeat (7) @(negedge clk);
      en = 1'b1;
      @(negedge clk);
      check("abort_beats_commit", outs(), pack(12'h100, 12'h002, 12'h010, 1'b0, 2'd0, 2'd2));
      key_mode = 1'b0;
      repeat (10) @(negedge clk);
      en = 1'b0;
      @(negedge clk);
      check("abort_commit_no_cfg", 64'(cfg_cnt - base), 64'd0);

      // Held inc key.
      press(OP_MODE);
      key_inc = 1'b1;
      repeat (30) @(negedge clk);
      key_inc = 1'b0;
      repeat (12) @(negedge clk);
      repeat (3) press(OP_MODE);
`ifdef TARIFF_AUTOREPEAT_EN
      s_ar = 12'h500;
`else
      s_ar = 12'h200;
`endif
      check("hold_inc", outs(), pack(s_ar, 12'h002, 12'h010, 1'b0, 2'd0, 2'd2));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
